// File: rtl/uart_pkg.sv
// Shared UART definitions: default byte width and the drain FSM state type.
// Reused by both the TX and RX buffers.
package uart_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } drain_state_t;

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Circular FIFO: storage, pointers, count and full/empty.
// A write while full is dropped, even when a pop happens in the same cycle.
module sync_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       wr_en,
  input  logic                       pop,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              wr_ok;
  logic              pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign wr_ok   = wr_en && !full;
  assign pop_ok  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok)  wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Contents are deliberately not reset; pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// TX buffer in front of uart_tx: FIFO plus drain FSM and optional sticky
// overflow flag (enabled by defining UART_TX_FIFO_OVF_EN).
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = uart_pkg::DATA_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   wr_en,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic [DATA_W-1:0]      tx_data,
  output logic                   tx_start,
  input  logic                   tx_done,
  output logic                   busy,
  output logic                   overflow,
  input  logic                   ovf_clr,
  output drain_state_t           fsm_state
);

  // Handshakes: the host may assert wr_en every cycle and the byte is taken
  // iff full is low that cycle; toward uart_tx, tx_start pulses once per byte
  // with tx_data held until tx_done, which only counts while in WAIT.

  drain_state_t      state;
  logic              pop;
  logic [DATA_W-1:0] rd_data;

  assign pop       = (state == IDLE) && !empty;
  assign busy      = (state != IDLE);
  assign fsm_state = state;

  sync_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_data (wr_data),
    .wr_en   (wr_en),
    .pop     (pop),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      tx_data  <= '0;
      tx_start <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        IDLE: begin
          if (!empty) begin
            tx_data  <= rd_data;
            tx_start <= 1'b1;
            state    <= START;
          end
        end
        START:   state <= WAIT;
        WAIT:    if (tx_done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef UART_TX_FIFO_OVF_EN
  // Set has priority over clear so a drop in the clearing cycle is not lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                overflow <= 1'b0;
    else if (wr_en && full)    overflow <= 1'b1;
    else if (ovf_clr)          overflow <= 1'b0;
  end
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;
  assign overflow       = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: cycle-level queue model, uart_tx
// responder and a monitor that scores every tx_start pulse.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef UART_TX_FIFO_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    wr_data;
  logic          wr_en;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic [7:0]    tx_data;
  logic          tx_start;
  logic          tx_done;
  logic          busy;
  logic          overflow;
  logic          ovf_clr;
  drain_state_t  fsm_state;

  uart_tx_fifo #(.DEPTH(DEPTH), .DATA_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_data   (wr_data),
    .wr_en     (wr_en),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .tx_done   (tx_done),
    .busy      (busy),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr),
    .fsm_state (fsm_state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc++;

  // Reference model: queue of stored bytes plus the one byte in flight.
  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  int         start_q[$];
  bit         inflight   = 1'b0;
  int         start_edge = 0;
  int         done_edge  = -1;
  int         free_at    = 0;
  logic [7:0] cur_data   = 8'h00;
  bit         m_ovf      = 1'b0;
  int         lat        = 20;
  bit         rand_lat   = 1'b0;
  bit         withhold   = 1'b0;
  bit         prev_start = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // One clock: drive inputs, advance the model to the coming edge, check state after it.
  task automatic step(input bit we, input logic [7:0] d, input bit clr, input bit spur);
    int e;
    bit td, accept, pop;
    @(negedge clk);
    e  = cyc + 1;
    td = inflight && (e == done_edge);
    if (spur && !td && (!inflight || e < start_edge + 2)) td = 1'b1;
    wr_en = we; wr_data = d; ovf_clr = clr; tx_done = td;
    pop    = !inflight && (e >= free_at) && (fifo_q.size() > 0);
    accept = we && (fifo_q.size() < DEPTH);
    if (OVF_EN) begin
      if (we && !accept) m_ovf = 1'b1;
      else if (clr)      m_ovf = 1'b0;
    end
    if (inflight && td && e >= start_edge + 2) begin
      inflight = 1'b0;
      free_at  = e + 1;
    end
    if (pop) begin
      cur_data   = fifo_q.pop_front();
      inflight   = 1'b1;
      start_edge = e;
      if (rand_lat) lat = $urandom_range(2, 6);
      done_edge  = withhold ? -1 : e + lat;
      exp_q.push_back(cur_data);
      start_q.push_back(e);
    end
    if (accept) fifo_q.push_back(d);
    @(posedge clk);
    #1;
    check("count", 32'(count), 32'(fifo_q.size()));
    check("empty", 32'(empty), 32'(fifo_q.size() == 0));
    check("full", 32'(full), 32'(fifo_q.size() == DEPTH));
    check("busy", 32'(busy), 32'(inflight));
    check("state_busy", 32'(fsm_state != IDLE), 32'(inflight));
    check("overflow", 32'(overflow), 32'(m_ovf));
    if (inflight && e != start_edge) check("tx_data_hold", 32'(tx_data), 32'(cur_data));
  endtask

  task automatic run_drain();
    int n = 0;
    while ((inflight || fifo_q.size() > 0) && n < 3000) begin
      step(1'b0, 8'h00, 1'b0, 1'b0);
      n++;
    end
    total++;
    if (n >= 3000) begin
      bad++;
      $display("FAIL drain_timeout: got %0d cycles, required under 3000", n);
    end
    repeat (3) step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0; wr_en = 1'b0; tx_done = 1'b0; ovf_clr = 1'b0;
    #1;
    fifo_q.delete(); exp_q.delete(); start_q.delete();
    inflight = 1'b0; done_edge = -1; m_ovf = 1'b0;
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset   = 1'b1;
    free_at = cyc + 1;
  endtask

  // Monitor: every tx_start must match the head of the expected queue, on time.
  always @(posedge clk) begin
    #1;
    if (start_q.size() > 0 && start_q[0] < cyc) begin
      total++; bad++;
      $display("FAIL missing_start: expected pulse at cycle %0d, none by %0d", start_q[0], cyc);
      void'(start_q.pop_front());
      void'(exp_q.pop_front());
    end
    if (tx_start) begin
      check("no_back_to_back", 32'(prev_start), 32'd0);
      if (start_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_start at cycle %0d: got tx_data %0h, required no pulse", cyc, tx_data);
      end else begin
        check("start_cycle", 32'(cyc), 32'(start_q.pop_front()));
        check("tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
      end
    end
    prev_start = tx_start;
  end

  initial begin
    reset = 1'b0; wr_en = 1'b0; wr_data = 8'h00; tx_done = 1'b0; ovf_clr = 1'b0;
    repeat (3) @(posedge clk);
    apply_reset();

    // Idle after reset: no pulses for 50 cycles.
    repeat (50) step(1'b0, 8'h00, 1'b0, 1'b0);

    // Single byte.
    lat = 20;
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    run_drain();

    // Burst of five.
    for (int i = 1; i <= 5; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    run_drain();

    // Fill with tx_done withheld; 18th byte dropped.
    withhold = 1'b1;
    for (int i = 1; i <= 18; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    withhold  = 1'b0;
    done_edge = cyc + 1;
    run_drain();

    // Random traffic across the pointer wrap, with coincident write/pop and stray tx_done.
    rand_lat = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 8'($urandom), 1'b0, $urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 2)) step(1'b0, 8'h00, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);
    end
    run_drain();
    rand_lat = 1'b0;

    // Reset mid-frame with three bytes queued.
    lat = 20;
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    repeat (3) step(1'b0, 8'h00, 1'b0, 1'b0);
    check("pre_reset_count", 32'(count), 32'd3);
    apply_reset();
    repeat (30) step(1'b0, 8'h00, 1'b0, 1'b0);

    check("pending_starts", 32'(start_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
